// File: rtl/fp_mul_issue_queue.sv
// rtl/fp_mul_issue_queue.sv - operand FIFO and issue sequencer for the single-precision multiplier
module fp_mul_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    output logic              mul_en,
    input  logic [31:0]       mul_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [ADDR_W:0]   count,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [63:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         mul_a_q, mul_a_d;
    logic [31:0]         mul_b_q, mul_b_d;
    logic                res_valid_q, res_valid_d;
    logic [31:0]         res_data_q, res_data_d;
    logic                push, pop, have_entry;

    // in_ready looks only at the registered count, so a full FIFO never pushes through a pop
    assign in_ready   = (count_q < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign have_entry = (count_q != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_entry) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  state_d = HOLD;
            HOLD: begin
                if (res_ready) begin
                    if (have_entry) begin
                        state_d = ISSUE;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        mul_a_d     = pop ? mem_q[rd_ptr_q][63:32] : mul_a_q;
        mul_b_d     = pop ? mem_q[rd_ptr_q][31:0]  : mul_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        // The multiplier's product becomes visible the cycle after the issue strobe
        if (state_q == WAIT) begin
            res_valid_d = 1'b1;
            res_data_d  = mul_result;
        end else if (state_q == HOLD && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_comb begin
        mul_en = (state_q == ISSUE);
        busy   = (state_q != IDLE) || have_entry;
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign count     = count_q;

endmodule
